// File: rtl/mult_pkg.sv
// Shared types for the HI/LO multiply unit: FSM state encoding and mfReg selects.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mult_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_FIX  = 2'd2
    } state_e;

    localparam logic [1:0] MF_NONE = 2'b00;
    localparam logic [1:0] MF_HI   = 2'b01;
    localparam logic [1:0] MF_LO   = 2'b10;

endpackage : mult_pkg

// File: rtl/mult_shift_add_dp.sv
// Shift-add datapath: latches operand magnitudes and sign, accumulates one multiplier bit per step.
// Latency: one bit per step_i cycle; product_o is valid combinationally once last_o has been consumed.
// Backpressure: none; load_i (restart) has priority over step_i.
// Ports: clk/rst_n (sync active-low); load_i/signed_i/srca_i/srcb_i start an operation;
//        step_i advances one iteration; last_o flags the final iteration; product_o is the signed-corrected result.
// Optional: MULT_EARLY_TERM_EN makes last_o also fire once the shifted-out multiplier is exhausted.
module mult_shift_add_dp #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load_i,
    input  logic               signed_i,
    input  logic [WIDTH-1:0]   srca_i,
    input  logic [WIDTH-1:0]   srcb_i,
    input  logic               step_i,
    output logic               last_o,
    output logic [2*WIDTH-1:0] product_o
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [CW-1:0]      count_q, count_d;
    logic               neg_q, neg_d;
    logic [WIDTH-1:0]   mag_a, mag_b;

    // Two's-complement negation of the most-negative value yields itself, which read
    // as unsigned is exactly the correct magnitude 2^(WIDTH-1).
    assign mag_a = (signed_i && srca_i[WIDTH-1]) ? -srca_i : srca_i;
    assign mag_b = (signed_i && srcb_i[WIDTH-1]) ? -srcb_i : srcb_i;

    always_comb begin
        mcand_d  = mcand_q;
        acc_d    = acc_q;
        mplier_d = mplier_q;
        count_d  = count_q;
        neg_d    = neg_q;
        if (load_i) begin
            mcand_d  = {{WIDTH{1'b0}}, mag_a};
            mplier_d = mag_b;
            acc_d    = '0;
            count_d  = '0;
            neg_d    = signed_i & (srca_i[WIDTH-1] ^ srcb_i[WIDTH-1]);
        end else if (step_i) begin
            if (mplier_q[0]) begin
                acc_d = acc_q + mcand_q;
            end
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            count_d  = count_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mcand_q  <= '0;
            acc_q    <= '0;
            mplier_q <= '0;
            count_q  <= '0;
            neg_q    <= 1'b0;
        end else begin
            mcand_q  <= mcand_d;
            acc_q    <= acc_d;
            mplier_q <= mplier_d;
            count_q  <= count_d;
            neg_q    <= neg_d;
        end
    end

`ifdef MULT_EARLY_TERM_EN
    // Remaining multiplier bits after this step's shift are all zero: nothing left to add.
    assign last_o = (count_q == CW'(WIDTH-1)) || (mplier_q[WIDTH-1:1] == '0);
`else
    assign last_o = (count_q == CW'(WIDTH-1));
`endif

    assign product_o = neg_q ? -acc_q : acc_q;

endmodule : mult_shift_add_dp

// File: rtl/mult_hilo_unit.sv
// Iterative mult/multu unit with architectural HI/LO registers and mfhi/mflo read mux.
// Latency: multReady low WIDTH+1 cycles after an accepted start (shorter with MULT_EARLY_TERM_EN).
// Backpressure: multStart ignored while StallE; a new start restarts any operation in flight.
// Ports: clk/rst_n (sync active-low); multStart/multSigned/StallE/srcA/srcB start a multiply;
//        hiWrite/loWrite load srcA into HI/LO; mfReg selects mfData (01 HI, 10 LO, else 0); multReady = idle.
// Optional: MULT_EARLY_TERM_EN (see mult_shift_add_dp) ends BUSY once the multiplier is exhausted.
import mult_pkg::*;

module mult_hilo_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             multStart,
    input  logic             multSigned,
    input  logic             StallE,
    input  logic [WIDTH-1:0] srcA,
    input  logic [WIDTH-1:0] srcB,
    input  logic             hiWrite,
    input  logic             loWrite,
    input  logic [1:0]       mfReg,
    output logic             multReady,
    output logic [WIDTH-1:0] mfData
);

    state_e             state_q;
    logic [WIDTH-1:0]   hi_q, lo_q;
    logic               start_acc;
    logic               dp_last;
    logic [2*WIDTH-1:0] dp_product;

    assign start_acc = multStart && !StallE;

    mult_shift_add_dp #(.WIDTH(WIDTH)) u_dp (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_i    (start_acc),
        .signed_i  (multSigned),
        .srca_i    (srcA),
        .srcb_i    (srcB),
        .step_i    (state_q == ST_BUSY),
        .last_o    (dp_last),
        .product_o (dp_product)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            if (hiWrite) hi_q <= srcA;
            if (loWrite) lo_q <= srcA;

            if (start_acc) begin
                // A restart discards whatever was in flight, including a pending FIX write.
                state_q <= ST_BUSY;
            end else begin
                case (state_q)
                    ST_BUSY: if (dp_last) state_q <= ST_FIX;
                    ST_FIX: begin
                        // Placed after mthi/mtlo so the product wins a same-edge conflict.
                        {hi_q, lo_q} <= dp_product;
                        state_q      <= ST_IDLE;
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign multReady = (state_q == ST_IDLE);

    always_comb begin
        mfData = '0;
        case (mfReg)
            MF_HI:   mfData = hi_q;
            MF_LO:   mfData = lo_q;
            default: mfData = '0;
        endcase
    end

endmodule : mult_hilo_unit

// File: doc/mult_hilo_unit.md
Name: mult_hilo_unit

Overview:
- Iterative shift-add multiplier with architectural HI/LO registers for the MIPS pipeline.
- Sits beside the ALU in the Execute stage and answers the hazard unit's multiply handshake.
- Accepts multStart, holds multReady low while computing, and serves mfhi/mflo reads through mfReg.
- Supports mult (signed) and multu (unsigned); mthi and mtlo write HI and LO directly.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits.

Ports:
- clk  in  1  pipeline clock
- rst_n  in  1  synchronous active-low reset
- multStart  in  1  start request from Execute (mult/multu decoded)
- multSigned  in  1  1 = mult, 0 = multu; sampled with multStart
- StallE  in  1  Execute stall; multStart is ignored while high
- srcA  in  WIDTH  multiplicand (rs)
- srcB  in  WIDTH  multiplier (rt)
- hiWrite  in  1  mthi: HI <= srcA
- loWrite  in  1  mtlo: LO <= srcA
- mfReg  in  2  01 = read HI, 10 = read LO, 00/11 = none
- multReady  out  1  high when idle and HI/LO are valid
- mfData  out  WIDTH  combinational read data: HI for 01, LO for 10, 0 otherwise

Behaviour:
- Reset (rst_n=0 at a clk edge): state IDLE, HI=0, LO=0, multReady=1, internal registers cleared.
- Reset mid-operation aborts the operation immediately; HI/LO are not written.
- States: IDLE, BUSY, FIX. multReady = (state==IDLE), decoded from the registered state.
- Start accepted when multStart && !StallE, in any state. A start during BUSY or FIX restarts with the new operands; the old result is discarded.
- On an accepted start, the following are latched:
  - mcand = zero-extended |srcA| to 2*WIDTH bits
  - mplier = |srcB|
  - acc = 0
  - neg = multSigned & (srcA[msb] ^ srcB[msb])
  - For multu, magnitudes are the raw values.
  - Then state <= BUSY, count <= 0.
- BUSY, each cycle:
  - if mplier[0], acc += mcand
  - mcand <<= 1; mplier >>= 1; count++
  - After the cycle with count==WIDTH-1, go to FIX.
- FIX, one cycle: {HI,LO} <= neg ? -acc : acc (2*WIDTH-bit two's complement), then state <= IDLE.
- Latency: multReady is low for exactly WIDTH+1 cycles after the accepting edge. For WIDTH=32 that is 33 cycles, and multReady is high again on the 34th.
- HI/LO keep their previous values until FIX writes them.
- mfData reads the current HI/LO. Stalling mf* until ready is the hazard unit's job.
- hiWrite/loWrite take effect at the edge in any state. If FIX writes on the same edge, the FIX product wins.
- hiWrite and loWrite may both be asserted; both HI and LO take srcA.
- Most-negative operand: the magnitude is treated as unsigned (2^(WIDTH-1)), which gives the correct product.

Optional Feature:
- Macro MULT_EARLY_TERM_EN.
- Defined: BUSY exits to FIX after any cycle where the post-shift mplier==0.
  - BUSY length = max(1, bit-length of |srcB|).
  - multReady low for BUSY length + 1 cycles.
- Undefined: fixed WIDTH BUSY cycles; count is the only exit condition.
- Results are identical either way.

Decomposition:
- Package mult_pkg holds:
  - the state enum (IDLE, BUSY, FIX)
  - mfReg encodings MF_NONE=2'b00, MF_HI=2'b01, MF_LO=2'b10
- One sub-module, mult_shift_add_dp, owns the mcand/mplier/acc registers, abs/negate logic and the count.
- The top level owns the FSM, HI/LO and the read mux.

Test Plan:
- Unsigned, full range: multu 0xFFFFFFFF × 0xFFFFFFFF, macro undefined → multReady low 33 cycles; HI=0xFFFFFFFE, LO=0x00000001.
- Signed, negative result: mult −3 × 5 → HI=0xFFFFFFFF, LO=0xFFFFFFF1; mfReg=10 gives 0xFFFFFFF1; mfReg=01 gives 0xFFFFFFFF.
- Restart and stall gating:
  - multStart with 2×2, then 10 cycles later multStart with 6×7 → HI=0, LO=42; ready 33 cycles after the second start.
  - multStart held with StallE=1 → no state change.
- Reset and direct writes:
  - rst_n=0 mid-BUSY → next cycle multReady=1, HI=LO=0.
  - mthi 0x1234 then mtlo 0x5678 → mfData reads back each value.
- Early termination, MULT_EARLY_TERM_EN defined: mult 7 × 3 → multReady low 3 cycles, LO=21.
- Early termination, zero multiplier: mult 0x80000000 × 0 → multReady low 2 cycles, HI=LO=0.
